// File: rtl/utt_pkg.sv
// Shared types and saturating arithmetic for the rhythm-game note engine and score display.
package utt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned MAX_LANES = 8;
  localparam int unsigned VIEW_W    = 8;
  localparam int unsigned CNT_W     = $clog2(MAX_LANES + 1);

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned max_v);
    return (a + b > max_v) ? max_v : a + b;
  endfunction

  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (b > a) ? 0 : a - b;
  endfunction

  // Net up/down applied in one step so a same-cycle hit and miss cancel before clamping.
  function automatic int unsigned clamp_delta(input int unsigned base, input int unsigned up,
                                              input int unsigned down, input int unsigned max_v);
    return sat_add(sat_sub(base + up, down), 0, max_v);
  endfunction

endpackage

// File: rtl/lane_shifter.sv
// One note lane: chart register, press edge detect and per-window judging.
// MISS_PENALTY_EN: a note shifted out unhit raises lost_c.
module lane_shifter
  import utt_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              active,
  input  logic              tick,
  input  logic              press,
  input  logic [DEPTH-1:0]  chart_lane,
  output logic [VIEW_W-1:0] view,
  output logic              hit_c,
  output logic              miss_c,
  output logic              lost_c,
  output logic              empty_c
);

  logic [DEPTH-1:0] lane;
  logic [DEPTH-1:0] lane_nxt;
  logic             press_q;
  logic             judged;
  logic             rise;
  logic             note_ok;

  // Judge against the pre-shift hit window, then load/shift/clear.
  always_comb begin
    rise     = press & ~press_q;
    note_ok  = lane[0] & ~judged;
    hit_c    = active & rise & note_ok;
    miss_c   = active & rise & ~note_ok;
`ifdef MISS_PENALTY_EN
    lost_c   = active & tick & lane[0] & ~hit_c;
`else
    lost_c   = 1'b0;
`endif
    lane_nxt = lane;
    if (load) begin
      lane_nxt = chart_lane;
    end else if (active) begin
      if (tick) begin
        lane_nxt = lane >> 1;
      end else if (hit_c) begin
        lane_nxt[0] = 1'b0;
      end
    end
    empty_c = (lane_nxt == '0);
  end

  always_ff @(posedge clk) begin
    press_q <= press;
    if (resetn) begin
      lane   <= '0;
      judged <= 1'b0;
    end else begin
      lane <= lane_nxt;
      if (load || (active && tick)) begin
        judged <= 1'b0;
      end else if (hit_c) begin
        judged <= 1'b1;
      end
    end
  end

  assign view = lane[VIEW_W-1:0];

endmodule

// File: rtl/lane_scorer.sv
// Multi-lane note engine: play/pause/done control plus score and combo keeping.
// MISS_PENALTY_EN (in lane_shifter): notes leaving unhit also count as misses.
module lane_scorer
  import utt_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned SCORE_W   = 8,
  parameter int unsigned COMBO_W   = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         running,
  input  logic                         lane_tick,
  input  logic [NUM_LANES-1:0]         press,
  input  logic [NUM_LANES*DEPTH-1:0]   chart,
  output logic [NUM_LANES*VIEW_W-1:0]  lane_view,
  output logic [SCORE_W-1:0]           score,
  output logic [COMBO_W-1:0]           combo,
  output logic [NUM_LANES-1:0]         hit,
  output logic [NUM_LANES-1:0]         miss,
  output logic                         done
);

  localparam int unsigned SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);
  localparam int unsigned COMBO_MAX = 32'((64'd1 << COMBO_W) - 64'd1);

  state_t                 state;
  logic [NUM_LANES-1:0]   hit_c;
  logic [NUM_LANES-1:0]   miss_c;
  logic [NUM_LANES-1:0]   lost_c;
  logic [NUM_LANES-1:0]   empty_c;
  logic [CNT_W-1:0]       hit_cnt;
  logic [CNT_W-1:0]       miss_cnt;
  logic                   all_empty;
  logic [SCORE_W-1:0]     score_nxt;
  logic [COMBO_W-1:0]     combo_nxt;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_shifter #(.DEPTH(DEPTH)) u_lane (
      .clk        (clk),
      .resetn     (resetn),
      .load       (state == IDLE),
      .active     (state == RUN),
      .tick       (lane_tick),
      .press      (press[g]),
      .chart_lane (chart[g*DEPTH +: DEPTH]),
      .view       (lane_view[g*VIEW_W +: VIEW_W]),
      .hit_c      (hit_c[g]),
      .miss_c     (miss_c[g]),
      .lost_c     (lost_c[g]),
      .empty_c    (empty_c[g])
    );
  end

  // Combine all lanes' verdicts into one score/combo step.
  always_comb begin
    hit_cnt   = '0;
    miss_cnt  = '0;
    all_empty = 1'b1;
    for (int l = 0; l < NUM_LANES; l++) begin
      hit_cnt   = hit_cnt + CNT_W'(hit_c[l]);
      miss_cnt  = miss_cnt + CNT_W'(miss_c[l] | lost_c[l]);
      all_empty = all_empty & empty_c[l];
    end
    score_nxt = SCORE_W'(clamp_delta(32'(score), 32'(hit_cnt), 32'(miss_cnt), SCORE_MAX));
    combo_nxt = (miss_cnt != '0) ? '0 : COMBO_W'(sat_add(32'(combo), 32'(hit_cnt), COMBO_MAX));
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state <= IDLE;
      score <= '0;
      combo <= '0;
      hit   <= '0;
      miss  <= '0;
      done  <= 1'b0;
    end else begin
      hit  <= '0;
      miss <= '0;
      case (state)
        IDLE: begin
          if (running) state <= RUN;
        end
        RUN: begin
          hit   <= hit_c;
          miss  <= miss_c | lost_c;
          score <= score_nxt;
          combo <= combo_nxt;
          if (all_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (!running) begin
            state <= PAUSE;
          end
        end
        PAUSE: begin
          if (running) state <= RUN;
        end
        DONE: begin
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_scorer.sv
// Bench for lane_scorer: spec-level lane/score model checked every cycle plus directed literals.
module tb_lane_scorer;

  localparam int NL = 4;
  localparam int DP = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          running = 1'b0;
  logic          lane_tick = 1'b0;
  logic [NL-1:0] press = '0;
  logic [NL*DP-1:0] chart = '0;

  logic [NL*8-1:0] lane_view, lane_view_s;
  logic [7:0]      score, combo;
  logic [3:0]      score_s, combo_s;
  logic [NL-1:0]   hit, miss, hit_s, miss_s;
  logic            done, done_s;

  int n_chk = 0;
  int n_pass = 0;

  lane_scorer #(.NUM_LANES(NL), .DEPTH(DP), .SCORE_W(8), .COMBO_W(8)) dut (
    .clk(clk), .resetn(resetn), .running(running), .lane_tick(lane_tick), .press(press),
    .chart(chart), .lane_view(lane_view), .score(score), .combo(combo), .hit(hit),
    .miss(miss), .done(done));

  // Narrow score/combo copy so saturation is reachable with a 16-deep chart.
  lane_scorer #(.NUM_LANES(NL), .DEPTH(DP), .SCORE_W(4), .COMBO_W(4)) dut_s (
    .clk(clk), .resetn(resetn), .running(running), .lane_tick(lane_tick), .press(press),
    .chart(chart), .lane_view(lane_view_s), .score(score_s), .combo(combo_s), .hit(hit_s),
    .miss(miss_s), .done(done_s));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [DP-1:0] m_lane [NL];
  bit            m_j [NL];
  logic [NL-1:0] m_prev, m_hit, m_miss;
  int            m_score, m_combo, m_score_s, m_combo_s, m_st;
  bit            m_valid = 0;

  function automatic int clampi(input int v, input int mx);
    return (v < 0) ? 0 : ((v > mx) ? mx : v);
  endfunction

  always @(posedge clk) begin : model
    logic [NL-1:0] rise;
    int h, m;
    bit empty;
    if (resetn) begin
      for (int l = 0; l < NL; l++) begin m_lane[l] = '0; m_j[l] = 0; end
      m_prev = press; m_hit = '0; m_miss = '0;
      m_score = 0; m_combo = 0; m_score_s = 0; m_combo_s = 0;
      m_st = M_IDLE; m_valid = 1;
    end else if (m_valid) begin
      rise = press & ~m_prev;
      m_prev = press;
      m_hit = '0; m_miss = '0;
      case (m_st)
        M_IDLE: begin
          for (int l = 0; l < NL; l++) begin m_lane[l] = chart[l*DP +: DP]; m_j[l] = 0; end
          if (running) m_st = M_RUN;
        end
        M_RUN: begin
          h = 0; m = 0; empty = 1;
          for (int l = 0; l < NL; l++) begin
            if (rise[l]) begin
              if (m_lane[l][0] && !m_j[l]) begin
                m_hit[l] = 1'b1; m_lane[l][0] = 1'b0; m_j[l] = 1; h++;
              end else begin
                m_miss[l] = 1'b1; m++;
              end
            end
            if (lane_tick) begin
`ifdef MISS_PENALTY_EN
              if (m_lane[l][0]) begin m_miss[l] = 1'b1; m++; end
`endif
              m_lane[l] = m_lane[l] >> 1;
              m_j[l] = 0;
            end
            if (m_lane[l] != '0) empty = 0;
          end
          m_score   = clampi(m_score + h - m, 255);
          m_score_s = clampi(m_score_s + h - m, 15);
          m_combo   = (m != 0) ? 0 : clampi(m_combo + h, 255);
          m_combo_s = (m != 0) ? 0 : clampi(m_combo_s + h, 15);
          if (empty) m_st = M_DONE;
          else if (!running) m_st = M_PAUSE;
        end
        M_PAUSE: if (running) m_st = M_RUN;
        default: ;
      endcase
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [NL*8-1:0] exp_view;
    if (m_valid) begin
      for (int l = 0; l < NL; l++) exp_view[l*8 +: 8] = m_lane[l][7:0];
      chk("lane_view", 64'(lane_view), 64'(exp_view));
      chk("score", 64'(score), 64'(m_score));
      chk("combo", 64'(combo), 64'(m_combo));
      chk("hit", 64'(hit), 64'(m_hit));
      chk("miss", 64'(miss), 64'(m_miss));
      chk("done", 64'(done), 64'(m_st == M_DONE));
      chk("score_s", 64'(score_s), 64'(m_score_s));
      chk("combo_s", 64'(combo_s), 64'(m_combo_s));
      chk("view_s", 64'(lane_view_s), 64'(exp_view));
      chk("hitmiss_s", 64'({hit_s, miss_s, done_s}), 64'({m_hit, m_miss, m_st == M_DONE}));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic run, input logic tk, input logic [NL-1:0] pr);
    running = run; lane_tick = tk; press = pr;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [NL*DP-1:0] c);
    resetn = 1'b1; running = 1'b0; lane_tick = 1'b0; press = '0; chart = c;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
  endtask

  initial begin
    // Single note hit ends the chart
    do_reset({16'h0000, 16'h0000, 16'h0000, 16'h0001});
    chk("rst_score", 64'(score), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_view", 64'(lane_view), 64'd0);
    step(1, 0, 4'b0000);
    chk("s1_load", 64'(lane_view[7:0]), 64'h01);
    step(1, 0, 4'b0001);
    chk("s1_hit", 64'(hit), 64'b0001);
    chk("s1_score", 64'(score), 64'd1);
    chk("s1_combo", 64'(combo), 64'd1);
    chk("s1_view", 64'(lane_view[7:0]), 64'h00);
    chk("s1_done", 64'(done), 64'd1);
    step(1, 1, 4'b0000);
    step(1, 0, 4'b0010);
    chk("s1_hold", 64'({done, score, hit, miss}), 64'({1'b1, 8'd1, 4'b0, 4'b0}));

    // Wrong press at zero score stays floored
    do_reset({16'h0000, 16'h0000, 16'h0002, 16'h00F0});
    step(1, 0, 4'b0000);
    step(1, 0, 4'b0010);
    chk("s2_miss", 64'(miss), 64'b0010);
    chk("s2_score", 64'(score), 64'd0);
    chk("s2_combo", 64'(combo), 64'd0);

    // Score 5, then three-lane press with one wrong lane
    do_reset({16'hFFDF, 16'hFFFF, 16'h0000, 16'hFFFF});
    step(1, 0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 4'b0001);
      step(1, 1, 4'b0000);
    end
    chk("s3_pre", 64'({score, combo}), 64'({8'd5, 8'd5}));
    step(1, 0, 4'b1101);
    chk("s3_hit", 64'(hit), 64'b0101);
    chk("s3_miss", 64'(miss), 64'b1000);
    chk("s3_score", 64'(score), 64'd6);
    chk("s3_combo", 64'(combo), 64'd0);

    // Press on tick cycle, then press into an empty window
    do_reset({16'h0000, 16'h0000, 16'h0000, 16'h0005});
    step(1, 0, 4'b0000);
    step(1, 1, 4'b0001);
    chk("s4_hit", 64'({hit, score, combo}), 64'({4'b0001, 8'd1, 8'd1}));
    chk("s4_view", 64'(lane_view[7:0]), 64'h02);
    step(1, 0, 4'b0000);
    step(1, 0, 4'b0001);
    chk("s4_miss", 64'({miss, score, combo}), 64'({4'b0001, 8'd0, 8'd0}));

    // Saturation on the narrow instance
    do_reset({4{16'hFFFF}});
    step(1, 0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 4'b1111);
      step(1, 1, 4'b0000);
    end
    chk("s5_score_s", 64'(score_s), 64'd15);
    chk("s5_combo_s", 64'(combo_s), 64'd15);
    chk("s5_score", 64'(score), 64'd20);
    chk("s5_combo", 64'(combo), 64'd20);

    // Unhit note leaving the window
    do_reset({16'h0000, 16'h0000, 16'h0100, 16'h000F});
    step(1, 0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 4'b0001);
      step(1, 1, 4'b0000);
    end
    chk("s6_pre", 64'({score, lane_view[7:0]}), 64'({8'd3, 8'h01}));
    step(1, 1, 4'b0000);
`ifdef MISS_PENALTY_EN
    chk("s6_lost", 64'({miss, score, combo}), 64'({4'b0001, 8'd2, 8'd0}));
`else
    chk("s6_lost", 64'({miss, score, combo}), 64'({4'b0000, 8'd3, 8'd3}));
`endif
    chk("s6_view", 64'(lane_view[15:0]), 64'h1000);

    // Pause freezes lanes; a held button never scores on resume
    do_reset({16'h0000, 16'h0000, 16'h0000, 16'h0003});
    step(1, 0, 4'b0000);
    step(0, 0, 4'b0000);
    step(0, 1, 4'b0001);
    chk("s7_pause", 64'({lane_view[7:0], score, hit}), 64'({8'h03, 8'd0, 4'b0}));
    step(1, 0, 4'b0001);
    chk("s7_held", 64'({score, hit}), 64'({8'd0, 4'b0}));
    step(1, 0, 4'b0000);
    step(1, 0, 4'b0001);
    chk("s7_hit", 64'({score, hit}), 64'({8'd1, 4'b0001}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
